mc_control_fsm: RTL and testbench

Parametrised multi-cycle MIPS control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction. It drives every datapath select and enable in the multi-cycle CPU top. Relative to the first-generation control unit it adds:
- a memory ready/request handshake, so instruction and data memory may insert wait states;
- optional `bne` and `j` support;
- an `illegal_instr` flag.

---
 rtl/mc_ctrl_pkg.sv | 49 ++++
 rtl/mc_alu_decoder.sv | 27 ++
 rtl/mc_control_fsm.sv | 197 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcode/funct
// values, ALU operation codes and datapath select codes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUB_RT    = 2'b00;
   localparam logic [1:0] ALUB_INC   = 2'b01;
   localparam logic [1:0] ALUB_IMM   = 2'b10;
   localparam logic [1:0] ALUB_SHIMM = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps an R-type funct field to the ALU operation code and flags unknown functs.
module mc_alu_decoder
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       funct_valid
);

   // Funct lookup; unknown functs fall back to add and are flagged invalid.
   always_comb begin
      alu_ctrl    = ALU_ADD;
      funct_valid = 1'b1;
      case (funct)
         FN_ADD: alu_ctrl = ALU_ADD;
         FN_SUB: alu_ctrl = ALU_SUB;
         FN_AND: alu_ctrl = ALU_AND;
         FN_OR:  alu_ctrl = ALU_OR;
         FN_SLT: alu_ctrl = ALU_SLT;
         default: begin
            alu_ctrl    = ALU_ADD;
            funct_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control unit for the multi-cycle MIPS datapath with memory wait states,
// optional bne/j support and an illegal-instruction pulse.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter logic ENABLE_BNE  = 1'b1,
   parameter logic ENABLE_JUMP = 1'b1,
   parameter int   ALU_CTRL_W  = 3
)(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [5:0]            opcode,
   input  logic [5:0]            funct,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  IorD,
   output logic                  ir_write,
   output logic                  mem_write,
   output logic                  pc_write,
   output logic                  branch,
   output logic                  branch_ne,
   output logic [1:0]            pc_src,
   output logic                  alu_src_A,
   output logic [1:0]            alu_src_B,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  reg_dst,
   output logic                  mem_to_reg,
   output logic                  reg_write,
   output logic                  illegal_instr,
   output logic [3:0]            state_dbg
);

   state_t     state_r;
   state_t     next_state_s;
   logic       mem_req_s, iord_s, ir_write_s, mem_write_s, pc_write_s;
   logic       branch_s, branch_ne_s, alu_src_a_s, reg_dst_s, mem_to_reg_s;
   logic       reg_write_s, illegal_s, funct_valid_s;
   logic [1:0] pc_src_s, alu_src_b_s;
   logic [2:0] alu_ctrl_s, dec_alu_s;

   mc_alu_decoder u_alu_decoder (
      .funct       (funct),
      .alu_ctrl    (dec_alu_s),
      .funct_valid (funct_valid_s)
   );

   // State register; reset parks the machine in FETCH.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and Moore outputs; memory strobes are additionally gated by mem_ready.
   always_comb begin
      next_state_s = S_FETCH;
      mem_req_s    = 1'b0;
      iord_s       = 1'b0;
      ir_write_s   = 1'b0;
      mem_write_s  = 1'b0;
      pc_write_s   = 1'b0;
      branch_s     = 1'b0;
      branch_ne_s  = 1'b0;
      pc_src_s     = PC_SRC_ALU;
      alu_src_a_s  = 1'b0;
      alu_src_b_s  = ALUB_RT;
      alu_ctrl_s   = ALU_ADD;
      reg_dst_s    = 1'b0;
      mem_to_reg_s = 1'b0;
      reg_write_s  = 1'b0;
      illegal_s    = 1'b0;
      case (state_r)
         S_FETCH: begin
            mem_req_s   = 1'b1;
            alu_src_b_s = ALUB_INC;
            if (mem_ready) begin
               ir_write_s   = 1'b1;
               pc_write_s   = 1'b1;
               next_state_s = S_DECODE;
            end else begin
               next_state_s = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_b_s = ALUB_SHIMM;
            case (opcode)
               OP_LW, OP_SW: next_state_s = S_MEMADR;
               OP_RTYPE:     next_state_s = S_EXEC;
               OP_BEQ:       next_state_s = S_BRANCH;
               OP_ADDI:      next_state_s = S_ADDIEX;
               OP_BNE: begin
                  if (ENABLE_BNE) begin
                     next_state_s = S_BRANCH;
                  end else begin
                     illegal_s = 1'b1;
                  end
               end
               OP_J: begin
                  if (ENABLE_JUMP) begin
                     next_state_s = S_JUMP;
                  end else begin
                     illegal_s = 1'b1;
                  end
               end
               default: illegal_s = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = ALUB_IMM;
            if (opcode == OP_SW) begin
               next_state_s = S_MEMWR;
            end else begin
               next_state_s = S_MEMRD;
            end
         end
         S_MEMRD: begin
            mem_req_s = 1'b1;
            iord_s    = 1'b1;
            if (mem_ready) begin
               next_state_s = S_MEMWB;
            end else begin
               next_state_s = S_MEMRD;
            end
         end
         S_MEMWB: begin
            mem_to_reg_s = 1'b1;
            reg_write_s  = 1'b1;
         end
         S_MEMWR: begin
            mem_req_s = 1'b1;
            iord_s    = 1'b1;
            if (mem_ready) begin
               mem_write_s  = 1'b1;
               next_state_s = S_FETCH;
            end else begin
               next_state_s = S_MEMWR;
            end
         end
         S_EXEC: begin
            alu_src_a_s = 1'b1;
            alu_ctrl_s  = dec_alu_s;
            if (funct_valid_s) begin
               next_state_s = S_ALUWB;
            end else begin
               illegal_s = 1'b1;
            end
         end
         S_ALUWB: begin
            reg_dst_s   = 1'b1;
            reg_write_s = 1'b1;
         end
         S_BRANCH: begin
            // BRANCH is only entered for beq, or bne when it is enabled.
            alu_src_a_s = 1'b1;
            alu_ctrl_s  = ALU_SUB;
            pc_src_s    = PC_SRC_ALUOUT;
            branch_s    = (opcode == OP_BEQ);
            branch_ne_s = (opcode == OP_BNE);
         end
         S_ADDIEX: begin
            alu_src_a_s  = 1'b1;
            alu_src_b_s  = ALUB_IMM;
            next_state_s = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write_s = 1'b1;
         end
         S_JUMP: begin
            pc_write_s = 1'b1;
            pc_src_s   = PC_SRC_JUMP;
         end
         default: next_state_s = S_FETCH;
      endcase
   end

   // Holding rstn low forces every output low, including any write strobe in flight.
   assign mem_req       = rstn & mem_req_s;
   assign IorD          = rstn & iord_s;
   assign ir_write      = rstn & ir_write_s;
   assign mem_write     = rstn & mem_write_s;
   assign pc_write      = rstn & pc_write_s;
   assign branch        = rstn & branch_s;
   assign branch_ne     = rstn & branch_ne_s;
   assign pc_src        = rstn ? pc_src_s : 2'b00;
   assign alu_src_A     = rstn & alu_src_a_s;
   assign alu_src_B     = rstn ? alu_src_b_s : 2'b00;
   assign alu_control   = rstn ? ALU_CTRL_W'(alu_ctrl_s) : '0;
   assign reg_dst       = rstn & reg_dst_s;
   assign mem_to_reg    = rstn & mem_to_reg_s;
   assign reg_write     = rstn & reg_write_s;
   assign illegal_instr = rstn & illegal_s;
   assign state_dbg     = rstn ? 4'(state_r) : 4'd0;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench: a path-based instruction model drives a per-cycle compare of
// two control units (default build, and one with bne/j disabled).
module tb_mc_control_fsm;

   typedef struct packed {
      logic       mem_req, iord, ir_write, mem_write, pc_write, branch, branch_ne;
      logic [1:0] pc_src;
      logic       alu_a;
      logic [1:0] alu_b;
      logic [2:0] alu_ctl;
      logic       reg_dst, mem_to_reg, reg_write, illegal;
      logic [3:0] st;
   } out_t;

   typedef struct {
      bit         main_rst;
      bit         nb_rst;
      bit         first;
      int         st;
      logic       mr;
      logic [5:0] op;
      logic [5:0] fn;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn, rstn_nb, mem_ready;
   logic [5:0] opcode, funct;

   logic a_mem_req, a_iord, a_ir_write, a_mem_write, a_pc_write, a_branch, a_branch_ne;
   logic a_alu_a, a_reg_dst, a_mem_to_reg, a_reg_write, a_illegal;
   logic [1:0] a_pc_src, a_alu_b;
   logic [2:0] a_alu_ctl;
   logic [3:0] a_st;
   logic b_mem_req, b_iord, b_ir_write, b_mem_write, b_pc_write, b_branch, b_branch_ne;
   logic b_alu_a, b_reg_dst, b_mem_to_reg, b_reg_write, b_illegal;
   logic [1:0] b_pc_src, b_alu_b;
   logic [2:0] b_alu_ctl;
   logic [3:0] b_st;
   out_t a_out, b_out;

   assign a_out = {a_mem_req, a_iord, a_ir_write, a_mem_write, a_pc_write, a_branch, a_branch_ne,
                   a_pc_src, a_alu_a, a_alu_b, a_alu_ctl, a_reg_dst, a_mem_to_reg, a_reg_write,
                   a_illegal, a_st};
   assign b_out = {b_mem_req, b_iord, b_ir_write, b_mem_write, b_pc_write, b_branch, b_branch_ne,
                   b_pc_src, b_alu_a, b_alu_b, b_alu_ctl, b_reg_dst, b_mem_to_reg, b_reg_write,
                   b_illegal, b_st};

   mc_control_fsm dut (
      .clk(clk), .rstn(rstn), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .mem_req(a_mem_req), .IorD(a_iord), .ir_write(a_ir_write), .mem_write(a_mem_write),
      .pc_write(a_pc_write), .branch(a_branch), .branch_ne(a_branch_ne), .pc_src(a_pc_src),
      .alu_src_A(a_alu_a), .alu_src_B(a_alu_b), .alu_control(a_alu_ctl), .reg_dst(a_reg_dst),
      .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write), .illegal_instr(a_illegal),
      .state_dbg(a_st)
   );

   mc_control_fsm #(.ENABLE_BNE(1'b0), .ENABLE_JUMP(1'b0), .ALU_CTRL_W(3)) dut_nb (
      .clk(clk), .rstn(rstn_nb), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .mem_req(b_mem_req), .IorD(b_iord), .ir_write(b_ir_write), .mem_write(b_mem_write),
      .pc_write(b_pc_write), .branch(b_branch), .branch_ne(b_branch_ne), .pc_src(b_pc_src),
      .alu_src_A(b_alu_a), .alu_src_B(b_alu_b), .alu_control(b_alu_ctl), .reg_dst(b_reg_dst),
      .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write), .illegal_instr(b_illegal),
      .state_dbg(b_st)
   );

   int   checks = 0;
   int   errors = 0;
   rec_t exp_q[$];
   out_t obs[0:31];
   int   cyc = 0;

   function automatic bit fn_ok(input logic [5:0] fn);
      return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
             fn == 6'b100101 || fn == 6'b101010;
   endfunction

   function automatic logic [2:0] fn_alu(input logic [5:0] fn);
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic bit op_ok(input logic [5:0] op, input bit en);
      case (op)
         6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000: return 1'b1;
         6'b000101, 6'b000010: return en;
         default: return 1'b0;
      endcase
   endfunction

   // Expected outputs of one state from the state table.
   function automatic out_t exp_out(input rec_t r, input bit en);
      out_t o;
      o = '0;
      o.alu_ctl = 3'b010;
      o.st = 4'(r.st);
      case (r.st)
         0:  begin o.mem_req = 1'b1; o.alu_b = 2'b01; o.ir_write = r.mr; o.pc_write = r.mr; end
         1:  begin o.alu_b = 2'b11; o.illegal = !op_ok(r.op, en); end
         2:  begin o.alu_a = 1'b1; o.alu_b = 2'b10; end
         3:  begin o.mem_req = 1'b1; o.iord = 1'b1; end
         4:  begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
         5:  begin o.mem_req = 1'b1; o.iord = 1'b1; o.mem_write = r.mr; end
         6:  begin o.alu_a = 1'b1; o.alu_ctl = fn_alu(r.fn); o.illegal = !fn_ok(r.fn); end
         7:  begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
         8:  begin
                o.alu_a = 1'b1; o.alu_ctl = 3'b110; o.pc_src = 2'b01;
                o.branch = (r.op == 6'b000100); o.branch_ne = (r.op == 6'b000101);
             end
         9:  begin o.alu_a = 1'b1; o.alu_b = 2'b10; end
         10: o.reg_write = 1'b1;
         11: begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
         default: ;
      endcase
      return o;
   endfunction

   function automatic rec_t mk(input bit nb, input int st, input logic mr,
                               input logic [5:0] op, input logic [5:0] fn);
      rec_t r;
      r.main_rst = nb; r.nb_rst = !nb; r.first = 1'b0;
      r.st = st; r.mr = mr; r.op = op; r.fn = fn;
      return r;
   endfunction

   task automatic check_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_vec(input string nm, input out_t act, input out_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic drive(input rec_t r);
      @(posedge clk);
      #1;
      rstn = !r.main_rst;
      rstn_nb = !r.nb_rst;
      mem_ready = r.mr;
      opcode = r.op;
      funct = r.fn;
      exp_q.push_back(r);
   endtask

   // Builds the instruction's state path from the instruction class, then replays it.
   task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mw, input bit nb, input int exp_cycles);
      rec_t tr[$];
      bit en;
      en = !nb;
      for (int i = 0; i < fw; i++) tr.push_back(mk(nb, 0, 1'b0, op, fn));
      tr.push_back(mk(nb, 0, 1'b1, op, fn));
      tr.push_back(mk(nb, 1, 1'b1, op, fn));
      if (op_ok(op, en)) begin
         case (op)
            6'b100011: begin
               tr.push_back(mk(nb, 2, 1'b1, op, fn));
               for (int i = 0; i < mw; i++) tr.push_back(mk(nb, 3, 1'b0, op, fn));
               tr.push_back(mk(nb, 3, 1'b1, op, fn));
               tr.push_back(mk(nb, 4, 1'b1, op, fn));
            end
            6'b101011: begin
               tr.push_back(mk(nb, 2, 1'b1, op, fn));
               for (int i = 0; i < mw; i++) tr.push_back(mk(nb, 5, 1'b0, op, fn));
               tr.push_back(mk(nb, 5, 1'b1, op, fn));
            end
            6'b000000: begin
               tr.push_back(mk(nb, 6, 1'b1, op, fn));
               if (fn_ok(fn)) tr.push_back(mk(nb, 7, 1'b1, op, fn));
            end
            6'b000100, 6'b000101: tr.push_back(mk(nb, 8, 1'b1, op, fn));
            6'b001000: begin
               tr.push_back(mk(nb, 9, 1'b1, op, fn));
               tr.push_back(mk(nb, 10, 1'b1, op, fn));
            end
            6'b000010: tr.push_back(mk(nb, 11, 1'b1, op, fn));
            default: ;
         endcase
      end
      tr[0].first = 1'b1;
      check_int({nm, " cycles"}, tr.size(), exp_cycles);
      foreach (tr[i]) drive(tr[i]);
      @(negedge clk);
      #1;
   endtask

   // Per-cycle compare of both DUTs; the one held in reset must show all zeros.
   initial begin : compare
      rec_t cr;
      out_t ea, eb;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            cr = exp_q.pop_front();
            ea = cr.main_rst ? out_t'(0) : exp_out(cr, 1'b1);
            eb = cr.nb_rst ? out_t'(0) : exp_out(cr, 1'b0);
            check_vec("dut_default", a_out, ea);
            check_vec("dut_no_bne_j", b_out, eb);
            cyc = cr.first ? 1 : cyc + 1;
            if (cyc < 32) obs[cyc] = cr.nb_rst ? a_out : b_out;
         end
      end
   end

   initial begin : stimulus
      rec_t r;
      int cnt;
      rstn = 1'b0; rstn_nb = 1'b0; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0;
      r = mk(1'b0, 0, 1'b0, 6'd0, 6'd0);
      r.main_rst = 1'b1; r.nb_rst = 1'b1;
      repeat (3) drive(r);
      @(negedge clk); #1;
      check_int("reset outputs", int'(a_out), 0);

      run_instr("add", 6'b000000, 6'b100000, 0, 0, 1'b0, 4);
      cnt = 0;
      for (int i = 1; i <= 3; i++) cnt += int'(obs[i].reg_write);
      check_int("add no early reg_write", cnt, 0);
      check_int("add reg_write c4", int'(obs[4].reg_write), 1);
      check_int("add reg_dst c4", int'(obs[4].reg_dst), 1);
      check_int("add exec state", int'(obs[3].st), 6);
      check_int("add exec alu", int'(obs[3].alu_ctl), 2);

      run_instr("lw", 6'b100011, 6'b000000, 2, 3, 1'b0, 10);
      cnt = 0;
      for (int i = 1; i <= 10; i++) cnt += int'(obs[i].ir_write);
      check_int("lw ir_write count", cnt, 1);
      check_int("lw ir_write c3", int'(obs[3].ir_write), 1);
      check_int("lw mem_to_reg c10", int'(obs[10].mem_to_reg), 1);

      run_instr("sw", 6'b101011, 6'b000000, 0, 0, 1'b0, 4);
      run_instr("sw wait", 6'b101011, 6'b000000, 1, 2, 1'b0, 7);
      run_instr("beq", 6'b000100, 6'b000000, 0, 0, 1'b0, 3);
      run_instr("bne", 6'b000101, 6'b000000, 0, 0, 1'b0, 3);
      check_int("bne branch_ne c3", int'(obs[3].branch_ne), 1);
      check_int("bne pc_src c3", int'(obs[3].pc_src), 1);
      run_instr("addi", 6'b001000, 6'b000000, 0, 0, 1'b0, 4);
      run_instr("j", 6'b000010, 6'b000000, 0, 0, 1'b0, 3);
      check_int("j pc_write c3", int'(obs[3].pc_write), 1);
      check_int("j pc_src c3", int'(obs[3].pc_src), 2);
      run_instr("sub", 6'b000000, 6'b100010, 0, 0, 1'b0, 4);
      run_instr("and", 6'b000000, 6'b100100, 0, 0, 1'b0, 4);
      run_instr("or", 6'b000000, 6'b100101, 0, 0, 1'b0, 4);
      run_instr("slt", 6'b000000, 6'b101010, 0, 0, 1'b0, 4);
      check_int("slt exec alu", int'(obs[3].alu_ctl), 7);
      run_instr("bad funct", 6'b000000, 6'b111111, 0, 0, 1'b0, 3);
      check_int("bad funct illegal c3", int'(obs[3].illegal), 1);
      run_instr("after bad funct", 6'b001000, 6'b000000, 0, 0, 1'b0, 4);
      check_int("bad funct no reg_write", int'(obs[1].reg_write), 0);
      run_instr("bad opcode", 6'b111111, 6'b000000, 0, 0, 1'b0, 2);
      check_int("bad opcode illegal c2", int'(obs[2].illegal), 1);

      // Reset while a store is stalled in MEMWR.
      r = mk(1'b0, 0, 1'b1, 6'b101011, 6'd0);
      r.first = 1'b1;
      drive(r);
      drive(mk(1'b0, 1, 1'b1, 6'b101011, 6'd0));
      drive(mk(1'b0, 2, 1'b1, 6'b101011, 6'd0));
      drive(mk(1'b0, 5, 1'b0, 6'b101011, 6'd0));
      drive(mk(1'b0, 5, 1'b0, 6'b101011, 6'd0));
      @(negedge clk); #2;
      rstn = 1'b0;
      #1;
      check_int("rst mem_write", int'(a_mem_write), 0);
      check_int("rst state_dbg", int'(a_st), 0);
      check_int("rst all outputs", int'(a_out), 0);
      mem_ready = 1'b1;
      #1;
      check_int("rst mem_write ready", int'(a_mem_write), 0);
      r = mk(1'b0, 0, 1'b0, 6'd0, 6'd0);
      r.main_rst = 1'b1; r.nb_rst = 1'b1;
      drive(r);
      r = mk(1'b0, 0, 1'b0, 6'd0, 6'd0);
      r.first = 1'b1;
      drive(r);
      @(negedge clk); #1;
      check_int("release mem_req", int'(obs[1].mem_req), 1);
      check_int("release state", int'(obs[1].st), 0);
      run_instr("add after reset", 6'b000000, 6'b100000, 0, 0, 1'b0, 4);

      run_instr("nb bne", 6'b000101, 6'b000000, 0, 0, 1'b1, 2);
      check_int("nb bne illegal c2", int'(obs[2].illegal), 1);
      check_int("nb bne decode c2", int'(obs[2].st), 1);
      run_instr("nb j", 6'b000010, 6'b000000, 1, 0, 1'b1, 3);
      run_instr("nb beq", 6'b000100, 6'b000000, 0, 0, 1'b1, 3);
      run_instr("nb lw", 6'b100011, 6'b000000, 0, 1, 1'b1, 6);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
